wb_updown_counter: RTL and testbench

Wishbone classic-cycle slave peripheral that implements a programmable up/down counter. It sits directly downstream of the system's Wishbone master and decodes that master's CTRL write at offset 0x00 and COUNT read at offset 0x04. It adds a prescaler, a programmable wrap limit, a sticky wrap flag and an interrupt output. Single clock domain, 32-bit data bus.

---
 rtl/wb_counter_pkg.sv | 52 +++++
 rtl/updown_count_core.sv | 50 +++++
 rtl/wb_updown_counter.sv | 140 ++++++++++++++
 tb/tb_wb_updown_counter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_counter_pkg.sv
// Shared definitions for the Wishbone up/down counter: register map, CTRL bits, reset values.
package wb_counter_pkg;

  localparam int unsigned BUS_W     = 32;
  localparam int unsigned SEL_W     = BUS_W / 8;
  localparam int unsigned ADR_IDX_W = 3;

  // Word indices decoded from wb_adr_i[4:2]
  localparam logic [ADR_IDX_W-1:0] ADR_CTRL     = 3'd0;
  localparam logic [ADR_IDX_W-1:0] ADR_COUNT    = 3'd1;
  localparam logic [ADR_IDX_W-1:0] ADR_PRESCALE = 3'd2;
  localparam logic [ADR_IDX_W-1:0] ADR_LIMIT    = 3'd3;
  localparam logic [ADR_IDX_W-1:0] ADR_STATUS   = 3'd4;

  // CTRL and STATUS bit positions
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_UP     = 1;
  localparam int unsigned CTRL_CLR    = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;
  localparam int unsigned STATUS_WRAP = 0;

  // LIMIT resets to all ones; truncated to the counter width at the use site
  localparam logic [BUS_W-1:0] LIMIT_RST = '1;

  // Bus handshake states: HOLD blocks re-acking while the master keeps stb high
  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_ACK  = 2'd1,
    BUS_HOLD = 2'd2
  } bus_state_e;

  // Decoded request payload
  typedef struct packed {
    logic                 we;
    logic [ADR_IDX_W-1:0] idx;
    logic [SEL_W-1:0]     sel;
    logic [BUS_W-1:0]     dat;
  } wb_req_t;

  // Replace the bytes of old_v selected by sel with the matching bytes of new_v
  function automatic logic [BUS_W-1:0] byte_merge(input logic [BUS_W-1:0] old_v,
                                                  input logic [BUS_W-1:0] new_v,
                                                  input logic [SEL_W-1:0] sel);
    logic [BUS_W-1:0] r;
    r = old_v;
    for (int b = 0; b < int'(SEL_W); b++) begin
      if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/updown_count_core.sv
// Prescaled up/down counter with programmable wrap limit and a single-cycle wrap indication.
module updown_count_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PRE_W-1:0] prescale,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             wrap_pulse
);

  logic [PRE_W-1:0] pre_q;
  logic             tick_c;
  logic             at_bound_c;

  // Tick when the prescaler reaches PRESCALE; bound depends on direction
  always_comb begin
    tick_c     = en && (pre_q == prescale);
    at_bound_c = up ? (count >= limit) : (count == '0);
    wrap_pulse = tick_c && at_bound_c && !clr && !load;
  end

  // Prescaler and counter; CLR beats a load, a load beats a tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q <= '0;
      count <= '0;
    end else begin
      if (clr || !en || tick_c) pre_q <= '0;
      else                      pre_q <= pre_q + PRE_W'(1);

      if (clr) begin
        count <= '0;
      end else if (load) begin
        count <= load_val;
      end else if (tick_c) begin
        if (up) count <= at_bound_c ? '0 : count + WIDTH'(1);
        else    count <= at_bound_c ? limit : count - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/wb_updown_counter.sv
// Wishbone classic slave: register bank, bus handshake, sticky WRAP and interrupt around the count core.
module wb_updown_counter
  import wb_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             irq_o,
  output logic [WIDTH-1:0] count_o
);

  bus_state_e       state_q, state_d;
  wb_req_t          req_c;
  logic             req_valid_c;
  logic             wr_c;
  logic             clr_c, load_c, status_clr_c;
  logic [WIDTH-1:0] load_val_c;
  logic [31:0]      rdata_c;
  logic             wrap_pulse;

  logic             en_q, up_q, irq_en_q, wrap_q;
  logic [PRE_W-1:0] prescale_q;
  logic [WIDTH-1:0] limit_q;

  // Only adr[4:2] is decoded
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

  // Request decode and write side effects that feed the core
  always_comb begin
    req_c.we     = wb_we_i;
    req_c.idx    = wb_adr_i[4:2];
    req_c.sel    = wb_sel_i;
    req_c.dat    = wb_dat_i;
    req_valid_c  = wb_cyc_i && wb_stb_i && !wb_ack_o && (state_q == BUS_IDLE);
    wr_c         = req_valid_c && req_c.we;
    clr_c        = wr_c && (req_c.idx == ADR_CTRL) && req_c.sel[0] && req_c.dat[CTRL_CLR];
    load_c       = wr_c && (req_c.idx == ADR_COUNT);
    load_val_c   = WIDTH'(byte_merge(32'(count_o), req_c.dat, req_c.sel));
    status_clr_c = wr_c && (req_c.idx == ADR_STATUS) && req_c.sel[0] && req_c.dat[STATUS_WRAP];
  end

  // Read mux over pre-edge register state; unmapped offsets read 0
  always_comb begin
    rdata_c = '0;
    case (req_c.idx)
      ADR_CTRL: begin
        rdata_c[CTRL_EN]     = en_q;
        rdata_c[CTRL_UP]     = up_q;
        rdata_c[CTRL_IRQ_EN] = irq_en_q;
      end
      ADR_COUNT:    rdata_c = 32'(count_o);
      ADR_PRESCALE: rdata_c = 32'(prescale_q);
      ADR_LIMIT:    rdata_c = 32'(limit_q);
      ADR_STATUS:   rdata_c[STATUS_WRAP] = wrap_q;
      default:      rdata_c = '0;
    endcase
  end

  // Handshake state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= BUS_IDLE;
    else        state_q <= state_d;
  end

  // Handshake next state: one ack per strobe, wait for stb to drop before re-arming
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUS_IDLE: if (req_valid_c) state_d = BUS_ACK;
      BUS_ACK:  state_d = (wb_cyc_i && wb_stb_i) ? BUS_HOLD : BUS_IDLE;
      BUS_HOLD: if (!(wb_cyc_i && wb_stb_i)) state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  // Register bank, bus outputs, sticky WRAP and interrupt
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
      irq_o      <= 1'b0;
      en_q       <= 1'b0;
      up_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      wrap_q     <= 1'b0;
      prescale_q <= '0;
      limit_q    <= WIDTH'(LIMIT_RST);
    end else begin
      wb_ack_o <= (state_d == BUS_ACK);
      wb_dat_o <= req_valid_c ? rdata_c : '0;
      irq_o    <= wrap_q && irq_en_q;

      if (wr_c) begin
        case (req_c.idx)
          ADR_CTRL: if (req_c.sel[0]) begin
            en_q     <= req_c.dat[CTRL_EN];
            up_q     <= req_c.dat[CTRL_UP];
            irq_en_q <= req_c.dat[CTRL_IRQ_EN];
          end
          ADR_PRESCALE: prescale_q <= PRE_W'(byte_merge(32'(prescale_q), req_c.dat, req_c.sel));
          ADR_LIMIT:    limit_q    <= WIDTH'(byte_merge(32'(limit_q), req_c.dat, req_c.sel));
          default: ;
        endcase
      end

      // A new wrap wins over a same-edge write-1-clear
      if (wrap_pulse)        wrap_q <= 1'b1;
      else if (status_clr_c) wrap_q <= 1'b0;
    end
  end

  updown_count_core #(
    .WIDTH(WIDTH),
    .PRE_W(PRE_W)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en_q),
    .up         (up_q),
    .clr        (clr_c),
    .load       (load_c),
    .load_val   (load_val_c),
    .prescale   (prescale_q),
    .limit      (limit_q),
    .count      (count_o),
    .wrap_pulse (wrap_pulse)
  );

endmodule

// File: tb/tb_wb_updown_counter.sv
// Scoreboard bench for wb_updown_counter: reads push expectations, the ack monitor pops and compares.
module tb_wb_updown_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, irq_o;
  logic [31:0] count_o;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit          rd;
    logic [31:0] lo;
    logic [31:0] hi;
    string       tag;
  } sb_t;

  sb_t sb_q[$];

  wb_updown_counter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_sel_i (wb_sel_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .irq_o    (irq_o),
    .count_o  (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Ack monitor: every ack consumes one scoreboard entry; read data compared on reads
  always @(negedge clk) begin : mon_blk
    sb_t e;
    if (wb_ack_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_ack", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        if (e.rd) begin
          if (e.lo == e.hi) check(e.tag, wb_dat_o, e.lo);
          else check(e.tag, 32'((wb_dat_o >= e.lo) && (wb_dat_o <= e.hi)), 32'd1);
        end
      end
    end
  end

  // One transfer: called and returns at posedge+1; consumes a request edge and an idle edge
  task automatic wb_xfer(input string tag, input bit we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input logic [31:0] lo, input logic [31:0] hi);
    sb_q.push_back('{rd: !we, lo: lo, hi: hi, tag: tag});
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    @(posedge clk); #1;
    check({tag, "_ack"}, 32'(wb_ack_o), 32'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
    wb_xfer("wr", 1'b1, adr, dat, sel, 32'd0, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    wb_xfer(tag, 1'b0, adr, 32'd0, 4'hF, exp, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int acks;
    rst_n = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_sel_i = 4'h0; wb_adr_i = '0; wb_dat_i = '0;
    step(3);
    check("rst_ack",   32'(wb_ack_o), 32'd0);
    check("rst_dat",   wb_dat_o,      32'd0);
    check("rst_irq",   32'(irq_o),    32'd0);
    check("rst_count", count_o,       32'd0);
    rst_n = 1'b1;
    step(1);

    // Reset values of the register map
    rd("rst_ctrl",  32'h00, 32'h0);
    rd("rst_cnt",   32'h04, 32'h0);
    rd("rst_pre",   32'h08, 32'h0);
    rd("rst_limit", 32'h0C, 32'hFFFF_FFFF);
    rd("rst_stat",  32'h10, 32'h0);

    // Free-running up count, tick every cycle
    wr(32'h00, 32'h3);
    step(199);
    wb_xfer("run200", 1'b0, 32'h04, 32'd0, 4'hF, 32'd199, 32'd201);
    rd("run_wrap0", 32'h10, 32'h0);
    wr(32'h00, 32'h0);

    // Up wrap at LIMIT=5 with interrupt
    wr(32'h0C, 32'd5);
    wr(32'h04, 32'd4);
    wr(32'h00, 32'hB);
    check("up_cnt5", count_o, 32'd5);
    step(1);
    check("up_cnt0", count_o, 32'd0);
    check("up_irq_lag", 32'(irq_o), 32'd0);
    step(1);
    check("up_cnt1", count_o, 32'd1);
    check("up_irq", 32'(irq_o), 32'd1);
    wr(32'h00, 32'h8);
    rd("up_wrap1", 32'h10, 32'h1);

    // Down count with PRESCALE=3, wrap 0 -> LIMIT
    wr(32'h00, 32'h0);
    wr(32'h10, 32'h1);
    wr(32'h04, 32'd0);
    wr(32'h0C, 32'd9);
    wr(32'h08, 32'd3);
    wr(32'h00, 32'h9);
    check("dn_cnt0_a", count_o, 32'd0);
    step(2);
    check("dn_cnt0_b", count_o, 32'd0);
    step(1);
    check("dn_cnt9", count_o, 32'd9);
    step(3);
    check("dn_hold9", count_o, 32'd9);
    step(1);
    check("dn_cnt8", count_o, 32'd8);
    check("dn_irq", 32'(irq_o), 32'd1);
    wr(32'h00, 32'h8);
    rd("dn_wrap1", 32'h10, 32'h1);
    wr(32'h10, 32'h1);
    check("dn_irq_clr", 32'(irq_o), 32'd0);
    rd("dn_wrap0", 32'h10, 32'h0);

    // Byte-enable partial load of COUNT
    wr(32'h04, 32'd0);
    wr(32'h04, 32'h1234_5678, 4'b0011);
    check("sel_count", count_o, 32'h0000_5678);
    rd("sel_rd", 32'h04, 32'h0000_5678);

    // CLR beats a same-edge tick
    wr(32'h08, 32'd0);
    wr(32'h0C, 32'hFFFF_FFFF);
    wr(32'h04, 32'h100);
    wr(32'h00, 32'h3);
    check("clr_pre", count_o, 32'h101);
    wr(32'h00, 32'h7);
    check("clr_tick", count_o, 32'd1);
    rd("clr_rd0", 32'h00, 32'h3);
    wr(32'h00, 32'h0);
    wr(32'h04, 32'h55);

    // Strobe held well past the ack: exactly one ack
    sb_q.push_back('{rd: 1'b1, lo: 32'hFFFF_FFFF, hi: 32'hFFFF_FFFF, tag: "hold_rd"});
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 32'h0C; wb_sel_i = 4'hF;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (wb_ack_o) acks++;
    end
    check("hold_acks", 32'(acks), 32'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step(2);

    // Unmapped offset: acked, reads 0, no side effects
    wr(32'h18, 32'hFFFF_FFFF);
    rd("unm_rd18", 32'h18, 32'h0);
    rd("unm_rd14", 32'h14, 32'h0);
    rd("unm_ctrl", 32'h00, 32'h0);
    rd("unm_cnt",  32'h04, 32'h55);
    rd("unm_pre",  32'h08, 32'h0);
    rd("unm_lim",  32'h0C, 32'hFFFF_FFFF);
    rd("unm_stat", 32'h10, 32'h0);

    step(2);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
